fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  - IF stage of the pipelined RV32I core; owns the PC and instruction-memory requests.
//  - Drives the IF/ID register that feeds the decoder (id_instr -> decoder.instr).
//  - Handles decode stalls without losing a word, using a 1-entry skid buffer.
//  - Handles EX-stage redirects (branch/jump) by flushing.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//  clk            in   1   clock; all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  imem_req       out  1   read request this cycle (combinational from state)
//  imem_addr      out  32  byte address of request (= fetch_pc)
//  imem_rdata     in   32  word for the request issued the previous cycle (sync RAM)
//  stall          in   1   hazard unit: hold IF/ID contents
//  redirect_valid in   1   EX: redirect fetch; flush IF/ID
//  redirect_pc    in   32  redirect target
//  id_valid       out  1   IF/ID holds a real instruction
//  id_instr       out  32  instruction to decoder; 32'h0000_0013 (NOP) when !id_valid
//  id_pc          out  32  PC of id_instr
//  id_pc_plus4    out  32  id_pc + 4, mod 2^32
// BEHAVIOUR
//  - State: fetch_pc, inflight + inflight_pc, skid_valid + skid_instr + skid_pc, IF/ID regs.
//  - Reset values:
//    - fetch_pc = RESET_PC; inflight = 0; skid_valid = 0.
//    - id_valid = 0; id_instr = NOP; id_pc = 0; id_pc_plus4 = 4.
//    - imem_req = 0 while reset is high.
//  - imem_req = !reset && !redirect_valid && !skid_valid && !(stall && inflight).
//    - On request: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0); inflight <= 1; inflight_pc <= fetch_pc.
//    - Otherwise: inflight <= 0.
//  - inflight and skid_valid are never both 1.
//  - Not stalled: IF/ID <= skid if skid_valid, else inflight word (imem_rdata, inflight_pc).
//    - If neither is available: bubble (id_valid = 0, id_instr = NOP).
//    - skid_valid <= 0.
//  - Stalled: IF/ID holds; if inflight, skid <= {imem_rdata, inflight_pc} and skid_valid <= 1.
//  - Redirect has highest priority and overrides stall.
//    - fetch_pc <= {redirect_pc[31:2], 2'b00}.
//    - inflight <= 0; skid_valid <= 0; id_valid <= 0; no request that cycle.
//  - Latency: request in cycle N -> id_valid = 1 in cycle N+2.
//    - First word after reset release: id_valid = 1 in the 2nd cycle after release.
//    - Redirect in cycle R: target requested R+1, in IF/ID R+3.
//  - Steady state (no stall): one instruction per cycle, PCs consecutive by 4.
//  - Reset mid-operation wins over all: the state above is restored in one cycle.
// CONFIGURATION
//  - FETCH_MISALIGN_CHECK_EN defined: adds output id_misaligned (1 bit, reset 0).
//    - Redirect with redirect_pc[1:0] != 0: no imem request is issued for it.
//    - Next non-stalled cycle: IF/ID <= {valid = 1, instr = NOP, pc = redirect_pc, id_misaligned = 1}.
//    - Fetch then halts (imem_req = 0) until the next redirect or reset.
//  - Not defined: no id_misaligned port; redirect_pc[1:0] ignored (forced 00).
// TESTING
//  - Reset, RESET_PC = 0x100, no stall:
//    - Requests 0x100, 0x104, 0x108 on consecutive cycles.
//    - id_pc = 0x100 two cycles after release, then 0x104, 0x108; id_pc_plus4 = id_pc + 4.
//  - Stall for 3 cycles while a word for 0x108 is inflight:
//    - 0x108 captured in skid; imem_req low while skid full.
//    - After release: id_pc 0x108 then 0x10C; nothing lost or duplicated.
//  - Redirect to 0x2000 asserted together with stall:
//    - Next cycle id_valid = 0, id_instr = 0x0000_0013.
//    - imem_addr = 0x2000; id_pc = 0x2000 at R+3.
//  - fetch_pc = 0xFFFF_FFFC: next request address 0x0000_0000; id_pc_plus4 for that word = 0.
//  - Reset asserted mid-stall with skid full:
//    - Next cycle skid_valid = 0, id_valid = 0, imem_addr = RESET_PC.
//  - With FETCH_MISALIGN_CHECK_EN, redirect to 0x2002:
//    - id_misaligned = 1, id_pc = 0x2002, id_instr = NOP.
//    - imem_req stays 0 until redirect to 0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem reads, feeds IF/ID through a 1-entry skid.
// Optional FETCH_MISALIGN_CHECK_EN adds id_misaligned and halts on misaligned redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        id_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        halt;

  logic        src_valid;
  logic [31:0] src_instr;
  logic [31:0] src_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        halted;
  logic        mis_pending;
  logic [31:0] mis_pc;
  logic        mis_target;
  logic        src_mis;

  assign mis_target = |redirect_pc[1:0];
  assign halt       = halted;
`else
  logic unused_low;

  assign unused_low = ^redirect_pc[1:0];
  assign halt       = 1'b0;
`endif

  assign imem_addr = fetch_pc;
  assign imem_req  = !reset && !redirect_valid && !skid_valid
                   && !(stall && inflight) && !halt;

  // Skid has priority: it always holds the older word.
  always_comb begin
    src_valid = 1'b0;
    src_instr = NOP;
    src_pc    = inflight_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    src_mis   = 1'b0;
`endif
    if (skid_valid) begin
      src_valid = 1'b1;
      src_instr = skid_instr;
      src_pc    = skid_pc;
    end else if (inflight) begin
      src_valid = 1'b1;
      src_instr = imem_rdata;
      src_pc    = inflight_pc;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    else if (mis_pending) begin
      src_valid = 1'b1;
      src_instr = NOP;
      src_pc    = mis_pc;
      src_mis   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP;
      skid_pc     <= 32'd0;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd4;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      inflight   <= 1'b0;
      skid_valid <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= NOP;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (!stall) begin
        skid_valid <= 1'b0;
        id_valid   <= src_valid;
        id_instr   <= src_instr;
        if (src_valid) begin
          id_pc       <= src_pc;
          id_pc_plus4 <= src_pc + 32'd4;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= inflight_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halted        <= 1'b0;
      mis_pending   <= 1'b0;
      mis_pc        <= 32'd0;
      id_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      halted        <= mis_target;
      mis_pending   <= mis_target;
      mis_pc        <= redirect_pc;
      id_misaligned <= 1'b0;
    end else if (!stall) begin
      id_misaligned <= src_mis;
      if (src_mis) mis_pending <= 1'b0;
    end
  end
`endif

endmodule
